// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Time-multiplexed 7-segment driver for the elevator floor/status indicator.
//   A binary value accepted over a valid/ready handshake is converted to BCD
//   one bit per cycle (double-dabble), committed atomically to the display
//   digits, and scanned onto a shared active-low segment bus with optional
//   leading-zero blanking and an overflow dash pattern.
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  in_value is valid
//   in_ready  idle, a value can be accepted
//   in_value  unsigned binary value to display
//   blank_en  1 = blank leading zeros (sampled every scan slot)
//   seg_n     segments a..g on bits 0..6, active low, registered
//   an_n      digit enables, active low one-hot, registered
module seg7_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 8,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  in_value,
  input  logic                  blank_en,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIN_WIDTH-1:0] bin_sh;
  logic [BCD_W-1:0]   bcd_sh, bcd_adj, disp;
  logic               ovf_pend, ovf;
  logic               accept, shift_done;

  logic [CNT_W-1:0]   pre;
  logic [IDX_W-1:0]   idx;
  logic               scan_tick;
  logic [3:0]         cur_digit;
  logic               upper_zero;
  logic [6:0]         seg_nxt;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h18;
      default: return 7'h7F;
    endcase
  endfunction

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign shift_done = (bit_cnt == BIT_W'(BIN_WIDTH - 1));
  assign bcd_adj    = add3(bcd_sh);

  // Control FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (shift_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: no reset, an aborted conversion is never committed.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_sh   <= in_value;
      bcd_sh   <= '0;
      ovf_pend <= (64'(in_value) > MAX_VAL);
    end else if (state == SHIFT) begin
      bcd_sh <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_WIDTH-1]};
      bin_sh <= bin_sh << 1;
    end
  end

  // Bit counter and committed display state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else begin
      if (accept)              bit_cnt <= '0;
      else if (state == SHIFT) bit_cnt <= bit_cnt + 1'b1;
      if (state == COMMIT) begin
        disp <= bcd_sh;
        ovf  <= ovf_pend;
      end
    end
  end

  // Scan: idx names the digit loaded at the next scan edge, so digit 0 is
  // the first one shown after reset.
  assign scan_tick = (pre == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cur_digit  = disp[4*int'(idx) +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (ovf)                                 seg_nxt = 7'h3F;
    else if (blank_en && idx != '0 && upper_zero) seg_nxt = 7'h7F;
    else                                     seg_nxt = seg_code(cur_digit);
  end

  // Output registers reload on the scan edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre   <= '0;
      idx   <= '0;
      seg_n <= 7'h7F;
      an_n  <= '1;
    end else if (scan_tick) begin
      pre   <= '0;
      seg_n <= seg_nxt;
      an_n  <= ~(NUM_DIGITS'(1) << idx);
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid1, valid2;
  logic       rdy1, rdy2;
  logic [7:0] in_value;
  logic       blank_en;
  logic [6:0] seg1, seg2;
  logic [3:0] an1;
  logic [1:0] an2;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(4), .BIN_WIDTH(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid1), .in_ready(rdy1),
    .in_value(in_value), .blank_en(blank_en), .seg_n(seg1), .an_n(an1)
  );

  seg7_scan_display #(.NUM_DIGITS(2), .BIN_WIDTH(8), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid2), .in_ready(rdy2),
    .in_value(in_value), .blank_en(blank_en), .seg_n(seg2), .an_n(an2)
  );

  function automatic logic [3:0] get_an(input bit w);
    return w ? {2'b11, an2} : an1;
  endfunction

  function automatic logic [6:0] get_seg(input bit w);
    return w ? seg2 : seg1;
  endfunction

  function automatic logic get_rdy(input bit w);
    return w ? rdy2 : rdy1;
  endfunction

  // Reference model: segment pattern for digit d of value v on an nd-digit display.
  function automatic logic [6:0] exp_seg(input int v, input int d, input int nd, input bit bl);
    int p;
    int pd;
    int dig;
    p  = 1;
    pd = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    for (int i = 0; i < d; i++) pd = pd * 10;
    if (v > p - 1) return 7'h3F;
    if (bl && d > 0 && v < pd) return 7'h7F;
    dig = (v / pd) % 10;
    case (dig)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h18;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic push_expected(input int v, input int nd, input bit bl);
    exp_t e;
    for (int d = 0; d < nd; d++) begin
      e.an  = ~(4'b0001 << d);
      e.seg = exp_seg(v, d, nd, bl);
      sb.push_back(e);
    end
  endtask

  // Drive one value; returns the number of cycles in_ready was observed low.
  task automatic send(input bit w, input int v, output int low_cycles);
    in_value = 8'(v);
    if (w) valid2 = 1'b1;
    else   valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    low_cycles = 0;
    while (get_rdy(w) == 1'b0 && low_cycles < 100) begin
      low_cycles++;
      @(negedge clk);
    end
    if (low_cycles >= 100) begin
      checks++;
      $display("FAIL send_timeout value=%0d in_ready stayed low for %0d cycles", v, low_cycles);
    end
  endtask

  // Align to the start of a digit-0 slot, then compare every cycle of one scan frame.
  task automatic check_scan(input bit w, input int nd, input string name);
    int guard;
    exp_t e;
    guard = 0;
    while (get_an(w) == 4'hE && guard < 100) begin guard++; @(negedge clk); end
    while (get_an(w) != 4'hE && guard < 100) begin guard++; @(negedge clk); end
    if (guard >= 100) begin
      checks++;
      $display("FAIL %s_scan_timeout an_n=%h never reached digit 0", name, get_an(w));
      sb.delete();
      return;
    end
    for (int d = 0; d < nd; d++) begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (get_an(w) !== e.an || get_seg(w) !== e.seg)
          $display("FAIL %s d%0d cyc%0d an_n=%h seg_n=%h expected an_n=%h seg_n=%h",
                   name, d, c, get_an(w), get_seg(w), e.an, e.seg);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid1 = 1'b0; valid2 = 1'b0; in_value = '0; blank_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (seg1 !== 7'h7F) $display("FAIL reset_seg seg_n=%h expected 7f", seg1); else passed++;
    checks++; if (an1 !== 4'hF) $display("FAIL reset_an an_n=%h expected f", an1); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL reset_ready in_ready=%b expected 1", rdy1); else passed++;
    checks++; if (an2 !== 2'b11) $display("FAIL reset_an2 an_n=%b expected 11", an2); else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (an1 !== 4'hF) $display("FAIL reset_early_an an_n=%h expected f", an1); else passed++;
    @(negedge clk);
    checks++;
    if (an1 !== 4'hE || seg1 !== 7'h40)
      $display("FAIL reset_first_digit an_n=%h seg_n=%h expected e 40", an1, seg1);
    else passed++;
  endtask

  task automatic test_convert();
    int lc;
    blank_en = 1'b0;
    send(1'b0, 123, lc);
    checks++; if (lc !== 9) $display("FAIL convert_busy in_ready low %0d cycles expected 9", lc); else passed++;
    push_expected(123, 4, 1'b0);
    check_scan(1'b0, 4, "convert123");
  endtask

  task automatic test_blanking();
    int lc;
    int vals[3] = '{7, 0, 105};
    blank_en = 1'b1;
    foreach (vals[i]) begin
      send(1'b0, vals[i], lc);
      push_expected(vals[i], 4, 1'b1);
      check_scan(1'b0, 4, $sformatf("blank%0d", vals[i]));
    end
    blank_en = 1'b0;
  endtask

  task automatic test_overflow();
    int lc;
    int vals[3] = '{100, 99, 255};
    blank_en = 1'b0;
    foreach (vals[i]) begin
      send(1'b1, vals[i], lc);
      push_expected(vals[i], 2, 1'b0);
      check_scan(1'b1, 2, $sformatf("ovf%0d", vals[i]));
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int slots;
    int dig;
    logic [3:0] prev_an;
    blank_en = 1'b0;
    in_value = 8'd42;
    valid1 = 1'b1;
    repeat (3) @(negedge clk);
    in_value = 8'd77;
    guard = 0;
    while (rdy1 == 1'b0 && guard < 100) begin guard++; @(negedge clk); end
    checks++;
    if (guard >= 100) $display("FAIL b2b_wait in_ready stayed low %0d cycles", guard);
    else passed++;
    // 42 is now committed; 77 is pending on the bus with valid high.
    prev_an = an1;
    slots = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (rdy1 !== 1'b0) $display("FAIL b2b_accept77 in_ready=%b expected 0", rdy1);
        else passed++;
        valid1 = 1'b0;
      end
      if (an1 != prev_an) begin
        dig = 0;
        for (int i = 0; i < 4; i++) if (an1[i] == 1'b0) dig = i;
        slots++;
        checks++;
        if (seg1 !== exp_seg(42, dig, 4, 1'b0))
          $display("FAIL b2b_show42 d%0d seg_n=%h expected %h", dig, seg1, exp_seg(42, dig, 4, 1'b0));
        else passed++;
      end
      prev_an = an1;
    end
    checks++;
    if (slots < 2) $display("FAIL b2b_slots saw %0d slots expected at least 2", slots);
    else passed++;
    guard = 0;
    while (rdy1 == 1'b0 && guard < 100) begin guard++; @(negedge clk); end
    push_expected(77, 4, 1'b0);
    check_scan(1'b0, 4, "b2b77");
  endtask

  task automatic test_abort();
    blank_en = 1'b0;
    in_value = 8'd200;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL abort_ready in_ready=%b expected 1", rdy1); else passed++;
    push_expected(0, 4, 1'b0);
    check_scan(1'b0, 4, "abort");
    repeat (20) @(negedge clk);
    checks++; if (rdy1 !== 1'b1) $display("FAIL abort_idle in_ready=%b expected 1", rdy1); else passed++;
    push_expected(0, 4, 1'b0);
    check_scan(1'b0, 4, "abort_hold");
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
